// File: rtl/ex_mem_buf.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_buf
// Description : Two-entry elastic buffer carrying EX write-back results to MEM,
//               with a youngest-first forwarding lookup for the ID stage.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_wd_o,
  output logic              mem_wreg_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [ADDR_W-1:0] fwd_raddr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [1:0]        count_o
);

  localparam logic [1:0] c_empty = 2'd0;
  localparam logic [1:0] c_full  = 2'd2;

  logic [ADDR_W-1:0] r_wd   [2];
  logic              r_wreg [2];
  logic [DATA_W-1:0] r_data [2];
  logic              r_head;
  logic              r_tail;
  logic [1:0]        r_count;

  logic w_not_full;
  logic w_valid;
  logic w_push;
  logic w_pop;

  // Readiness depends only on occupancy, so a same-cycle pop never frees a slot.
  assign w_not_full = (r_count != c_full);
  assign w_valid    = (r_count != c_empty);
  assign w_push     = ex_valid_i & w_not_full & ~flush_i;
  assign w_pop      = w_valid & mem_ready_i & ~flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= c_empty;
      for (int i = 0; i < 2; i++) begin
        r_wd[i]   <= '0;
        r_wreg[i] <= 1'b0;
        r_data[i] <= '0;
      end
    end else if (flush_i) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= c_empty;
    end else begin
      if (w_push) begin
        r_wd[r_tail]   <= ex_wd_i;
        r_wreg[r_tail] <= ex_wreg_i;
        r_data[r_tail] <= ex_wdata_i;
        r_tail         <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign ex_ready_o  = rst & w_not_full;
  assign mem_valid_o = w_valid;
  assign count_o     = r_count;
  assign mem_wd_o    = w_valid ? r_wd[r_head]   : '0;
  assign mem_wreg_o  = w_valid ? r_wreg[r_head] : 1'b0;
  assign mem_wdata_o = w_valid ? r_data[r_head] : '0;

  // The youngest entry sits just behind the tail; the older one exists only when full.
  logic w_young;
  logic w_old;
  logic w_young_hit;
  logic w_old_hit;
  logic w_raddr_nz;

  assign w_young    = ~r_tail;
  assign w_old      = r_head;
  assign w_raddr_nz = (fwd_raddr_i != '0);

  assign w_young_hit = w_valid && w_raddr_nz && r_wreg[w_young]
                       && (r_wd[w_young] == fwd_raddr_i);
  assign w_old_hit   = (r_count == c_full) && w_raddr_nz && r_wreg[w_old]
                       && (r_wd[w_old] == fwd_raddr_i);

  assign fwd_hit_o  = w_young_hit | w_old_hit;
  assign fwd_data_o = w_young_hit ? r_data[w_young] :
                      w_old_hit   ? r_data[w_old]   : '0;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_buf
// Description : Directed bench for ex_mem_buf with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic [31:0] ex_wdata_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o;
  logic [31:0] mem_wdata_o;
  logic [4:0]  fwd_raddr_i;
  logic        fwd_hit_o;
  logic [31:0] fwd_data_o;
  logic [1:0]  count_o;

  ex_mem_buf #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
    .fwd_raddr_i(fwd_raddr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] data;
  } entry_t;

  entry_t q[$];
  int     errs   = 0;
  int     checks = 0;
  bit     done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is the queue length, order is queue order.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
    end else if (flush_i) begin
      q.delete();
    end else begin
      bit   do_push;
      bit   do_pop;
      entry_t e;
      do_push = ex_valid_i && (q.size() < 2);
      do_pop  = mem_ready_i && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.wd = ex_wd_i; e.wreg = ex_wreg_i; e.data = ex_wdata_i;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      logic        exp_hit;
      logic [31:0] exp_fd;
      exp_hit = 1'b0;
      exp_fd  = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!exp_hit && fwd_raddr_i != 0 && q[i].wreg && q[i].wd == fwd_raddr_i) begin
          exp_hit = 1'b1;
          exp_fd  = q[i].data;
        end
      end
      chk("count",     {30'd0, count_o}, q.size());
      chk("mem_valid", {31'd0, mem_valid_o}, {31'd0, q.size() != 0});
      chk("ex_ready",  {31'd0, ex_ready_o}, {31'd0, rst && q.size() < 2});
      chk("mem_wd",    {27'd0, mem_wd_o},    q.size() ? {27'd0, q[0].wd} : 32'd0);
      chk("mem_wreg",  {31'd0, mem_wreg_o},  q.size() ? {31'd0, q[0].wreg} : 32'd0);
      chk("mem_wdata", mem_wdata_o,          q.size() ? q[0].data : 32'd0);
      chk("fwd_hit",   {31'd0, fwd_hit_o}, {31'd0, exp_hit});
      chk("fwd_data",  fwd_data_o, exp_fd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] wd, input logic wreg, input logic [31:0] d);
    ex_valid_i = v; ex_wd_i = wd; ex_wreg_i = wreg; ex_wdata_i = d;
  endtask

  initial begin
    rst = 1'b0; flush_i = 1'b0; mem_ready_i = 1'b0; fwd_raddr_i = '0;
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    step(); step();
    chk("rst_ready", {31'd0, ex_ready_o}, 32'd0);
    chk("rst_count", {30'd0, count_o}, 32'd0);
    chk("rst_valid", {31'd0, mem_valid_o}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_ready", {31'd0, ex_ready_o}, 32'd1);

    // single transfer, 1-cycle latency
    mem_ready_i = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 32'h1234);
    step();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    chk("t1_valid", {31'd0, mem_valid_o}, 32'd1);
    chk("t1_wd",    {27'd0, mem_wd_o}, 32'd3);
    chk("t1_data",  mem_wdata_o, 32'h1234);
    step();
    chk("t1_count", {30'd0, count_o}, 32'd0);

    // fill, refused third push, ordered drain
    mem_ready_i = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 32'hA); step();
    drive(1'b1, 5'd2, 1'b1, 32'hB); step();
    chk("t2_ready", {31'd0, ex_ready_o}, 32'd0);
    chk("t2_count", {30'd0, count_o}, 32'd2);
    drive(1'b1, 5'd4, 1'b1, 32'hC); step();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    chk("t2_full_count", {30'd0, count_o}, 32'd2);
    chk("t2_head_a", mem_wdata_o, 32'hA);
    mem_ready_i = 1'b1;
    step();
    chk("t2_head_b", mem_wdata_o, 32'hB);
    step();
    chk("t2_empty", {30'd0, count_o}, 32'd0);

    // forwarding youngest-wins, zero address, then flush with EX input
    mem_ready_i = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 32'h11); step();
    drive(1'b1, 5'd5, 1'b1, 32'h22); step();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    fwd_raddr_i = 5'd5; #1;
    chk("t3_hit",  {31'd0, fwd_hit_o}, 32'd1);
    chk("t3_data", fwd_data_o, 32'h22);
    fwd_raddr_i = 5'd0; #1;
    chk("t3_zero_hit", {31'd0, fwd_hit_o}, 32'd0);
    chk("t3_zero_data", fwd_data_o, 32'd0);
    flush_i = 1'b1;
    drive(1'b1, 5'd7, 1'b1, 32'h77);
    step();
    flush_i = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    chk("t5_count", {30'd0, count_o}, 32'd0);
    chk("t5_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("t5_wd",    {27'd0, mem_wd_o}, 32'd0);
    chk("t5_data",  mem_wdata_o, 32'd0);

    // entry without register write is delivered but never forwards
    drive(1'b1, 5'd9, 1'b0, 32'h99); step();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    fwd_raddr_i = 5'd9; #1;
    chk("t3_nowreg_hit",  {31'd0, fwd_hit_o}, 32'd0);
    chk("t3_nowreg_data", fwd_data_o, 32'd0);
    chk("t3_nowreg_valid", {31'd0, mem_valid_o}, 32'd1);
    mem_ready_i = 1'b1;
    step();

    // concurrent push/pop at occupancy 1
    mem_ready_i = 1'b0;
    drive(1'b1, 5'd8, 1'b1, 32'h100); step();
    mem_ready_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      fwd_raddr_i = 5'd8;
      drive(1'b1, 5'd8, 1'b1, 32'h100 + i);
      step();
      chk("t4_count", {30'd0, count_o}, 32'd1);
      chk("t4_head", mem_wdata_o, 32'h100 + i);
    end
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    step();

    // asynchronous reset mid-cycle while full
    mem_ready_i = 1'b0;
    drive(1'b1, 5'd6, 1'b1, 32'h66); step();
    drive(1'b1, 5'd6, 1'b1, 32'h67); step();
    drive(1'b0, 5'd0, 1'b0, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("t6_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("t6_count", {30'd0, count_o}, 32'd0);
    chk("t6_ready", {31'd0, ex_ready_o}, 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk("t6_rel_ready", {31'd0, ex_ready_o}, 32'd1);
    chk("t6_rel_count", {30'd0, count_o}, 32'd0);
    step(); step();

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
